// File: rtl/fish_sprite_scheduler.sv
// Shares one fish sprite ROM among NUM_FISH on-screen fish with fixed-priority hit test and per-frame commit.
// Optional horizontal mirroring is enabled by defining FISH_FLIP_EN.
module fish_sprite_scheduler #(
   parameter int NUM_FISH = 4,
   parameter int FISH_W   = 15,
   parameter int FISH_H   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  hcount,
   input  logic [9:0]  vcount,
   input  logic        video_on,
   input  logic        frame_start,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [2:0]  wr_idx,
   input  logic [9:0]  wr_x,
   input  logic [9:0]  wr_y,
   input  logic        wr_en,
`ifdef FISH_FLIP_EN
   input  logic        wr_flip,
`endif
   output logic [2:0]  rom_row,
   output logic [3:0]  rom_col,
   input  logic [11:0] rom_color,
   output logic        pix_valid,
   output logic [11:0] pix_color,
   output logic [2:0]  pix_idx,
   output logic        overlap,
   output logic [7:0]  frame_cnt
);

   typedef enum logic [0:0] {RUN = 1'b0, COMMIT = 1'b1} state_t;
   state_t state, state_next;

   logic [9:0] sh_x   [NUM_FISH];
   logic [9:0] sh_y   [NUM_FISH];
   logic       sh_en  [NUM_FISH];
   logic [9:0] act_x  [NUM_FISH];
   logic [9:0] act_y  [NUM_FISH];
   logic       act_en [NUM_FISH];
`ifdef FISH_FLIP_EN
   logic       sh_flip  [NUM_FISH];
   logic       act_flip [NUM_FISH];
   logic       win_flip;
`endif

   logic [NUM_FISH-1:0] hit;
   logic                any_hit, multi_hit, wr_fire;
   logic [2:0]          win;
   logic [9:0]          win_x, win_y, col_off, row_off;
   logic                hit_d;
   logic [2:0]          idx_d;
   logic                opaque;

   always_comb begin
      state_next = state;
      wr_ready   = 1'b0;
      case (state)
         RUN: begin
            wr_ready = !reset;
            if (frame_start) state_next = COMMIT;
            else             state_next = RUN;
         end
         COMMIT:  state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   assign wr_fire = wr_valid && wr_ready;

   // 11-bit compares so sprites near the right/bottom edge clip instead of wrapping
   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_FISH; i++) begin
         hit[i] = video_on && act_en[i]
               && ({1'b0, hcount} >= {1'b0, act_x[i]})
               && ({1'b0, hcount} <  ({1'b0, act_x[i]} + 11'(FISH_W)))
               && ({1'b0, vcount} >= {1'b0, act_y[i]})
               && ({1'b0, vcount} <  ({1'b0, act_y[i]} + 11'(FISH_H)));
      end
   end

   assign multi_hit = (hit & (hit - {{(NUM_FISH-1){1'b0}}, 1'b1})) != '0;

   always_comb begin
      any_hit = 1'b0;
      win     = 3'd0;
      win_x   = 10'd0;
      win_y   = 10'd0;
`ifdef FISH_FLIP_EN
      win_flip = 1'b0;
`endif
      for (int i = NUM_FISH - 1; i >= 0; i--) begin
         if (hit[i]) begin
            any_hit = 1'b1;
            win     = 3'(i);
            win_x   = act_x[i];
            win_y   = act_y[i];
`ifdef FISH_FLIP_EN
            win_flip = act_flip[i];
`endif
         end
      end
      col_off = hcount - win_x;
      row_off = vcount - win_y;
      if (any_hit) begin
         rom_row = row_off[2:0];
`ifdef FISH_FLIP_EN
         if (win_flip) rom_col = 4'(FISH_W - 1) - col_off[3:0];
         else          rom_col = col_off[3:0];
`else
         rom_col = col_off[3:0];
`endif
      end else begin
         rom_row = 3'd0;
         rom_col = 4'd0;
      end
   end

   // Control state, slot banks, overlap flag and frame counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         overlap   <= 1'b0;
         frame_cnt <= 8'd0;
         for (int i = 0; i < NUM_FISH; i++) begin
            sh_x[i] <= 10'd0;  sh_y[i] <= 10'd0;  sh_en[i] <= 1'b0;
            act_x[i] <= 10'd0; act_y[i] <= 10'd0; act_en[i] <= 1'b0;
`ifdef FISH_FLIP_EN
            sh_flip[i] <= 1'b0; act_flip[i] <= 1'b0;
`endif
         end
      end else begin
         state <= state_next;
         for (int i = 0; i < NUM_FISH; i++) begin
            if (wr_fire && wr_idx == 3'(i)) begin
               sh_x[i]  <= wr_x;
               sh_y[i]  <= wr_y;
               sh_en[i] <= wr_en;
`ifdef FISH_FLIP_EN
               sh_flip[i] <= wr_flip;
`endif
            end
            if (state == COMMIT) begin
               act_x[i]  <= sh_x[i];
               act_y[i]  <= sh_y[i];
               act_en[i] <= sh_en[i];
`ifdef FISH_FLIP_EN
               act_flip[i] <= sh_flip[i];
`endif
            end
         end
         if (state == COMMIT) begin
            overlap   <= 1'b0;
            frame_cnt <= frame_cnt + 8'd1;
         end else if (multi_hit) begin
            overlap <= 1'b1;
         end else begin
            overlap <= overlap;
         end
      end
   end

   assign opaque = hit_d && (rom_color != 12'h000);

   // Hit info is delayed one cycle to line up with the ROM's registered output
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_d     <= 1'b0;
         idx_d     <= 3'd0;
         pix_valid <= 1'b0;
         pix_color <= 12'h000;
         pix_idx   <= 3'd0;
      end else begin
         hit_d     <= any_hit;
         idx_d     <= win;
         pix_valid <= opaque;
         pix_color <= opaque ? rom_color : 12'h000;
         pix_idx   <= hit_d ? idx_d : 3'd0;
      end
   end

endmodule

// File: tb/tb_fish_sprite_scheduler.sv
// Scoreboard bench for fish_sprite_scheduler: a reference slot/hit model predicts ROM address,
// pixel output, overlap and frame count; pixel expectations are queued and popped two cycles later.
module tb_fish_sprite_scheduler;
   localparam int NF = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  hcount = 10'd0, vcount = 10'd0;
   logic        video_on = 1'b0, frame_start = 1'b0, wr_valid = 1'b0;
   logic        wr_ready;
   logic [2:0]  wr_idx = 3'd0;
   logic [9:0]  wr_x = 10'd0, wr_y = 10'd0;
   logic        wr_en = 1'b0, wr_flip = 1'b0;
   logic [2:0]  rom_row;
   logic [3:0]  rom_col;
   logic [11:0] rom_color = 12'h000;
   logic        pix_valid;
   logic [11:0] pix_color;
   logic [2:0]  pix_idx;
   logic        overlap;
   logic [7:0]  frame_cnt;

   fish_sprite_scheduler #(.NUM_FISH(NF), .FISH_W(15), .FISH_H(8)) dut (
      .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
      .video_on(video_on), .frame_start(frame_start),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
      .wr_x(wr_x), .wr_y(wr_y), .wr_en(wr_en),
`ifdef FISH_FLIP_EN
      .wr_flip(wr_flip),
`endif
      .rom_row(rom_row), .rom_col(rom_col), .rom_color(rom_color),
      .pix_valid(pix_valid), .pix_color(pix_color), .pix_idx(pix_idx),
      .overlap(overlap), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] rom_fn(input logic [2:0] r, input logic [3:0] c);
      if (c == 4'd0) return 12'h000;
      if (r == 3'd1 && c == 4'd4) return 12'hFC6;
      return {1'b0, r, c, 4'h5};
   endfunction

   always @(posedge clk) rom_color <= rom_fn(rom_row, rom_col);

   typedef struct packed { logic v; logic [11:0] c; logic [2:0] i; } exp_t;
   exp_t q[$];

   int checks = 0;
   int errors = 0;

   int  sx[NF], sy[NF], ax[NF], ay[NF];
   bit  sen[NF], aen[NF], sfl[NF], afl[NF];
   bit  m_commit, m_ovl;
   int  m_cnt;

   task automatic model_clear();
      for (int i = 0; i < NF; i++) begin
         sx[i] = 0; sy[i] = 0; sen[i] = 0; sfl[i] = 0;
         ax[i] = 0; ay[i] = 0; aen[i] = 0; afl[i] = 0;
      end
      m_commit = 0; m_ovl = 0; m_cnt = 0;
      q.delete();
   endtask

   task automatic cycle(input int h, input int v, input bit vo, input bit fs);
      int win, nh, r, c;
      bit hit, acc;
      logic [11:0] rc;
      exp_t e, got;
      hcount = 10'(h); vcount = 10'(v); video_on = vo; frame_start = fs;
      win = 0; nh = 0; hit = 0;
      for (int i = NF - 1; i >= 0; i--)
         if (vo && aen[i] && h >= ax[i] && h < ax[i] + 15 && v >= ay[i] && v < ay[i] + 8) begin
            win = i; hit = 1; nh++;
         end
      r = hit ? v - ay[win] : 0;
      c = hit ? h - ax[win] : 0;
`ifdef FISH_FLIP_EN
      if (hit && afl[win]) c = 14 - c;
`endif
      #1;
      checks++;
      if (rom_row !== 3'(r) || rom_col !== 4'(c)) begin
         errors++;
         $display("FAIL rom_addr (%0d,%0d): got row %0d col %0d, want row %0d col %0d",
                  h, v, rom_row, rom_col, r, c);
      end
      checks++;
      if (wr_ready !== !m_commit) begin
         errors++;
         $display("FAIL wr_ready: got %b want %b", wr_ready, !m_commit);
      end
      rc = rom_fn(3'(r), 4'(c));
      e.v = hit && (rc != 12'h000);
      e.c = e.v ? rc : 12'h000;
      e.i = hit ? 3'(win) : 3'd0;
      q.push_back(e);
      acc = wr_valid && !m_commit;
      @(posedge clk); #1;
      if (acc && wr_idx < NF) begin
         sx[wr_idx] = int'(wr_x); sy[wr_idx] = int'(wr_y);
         sen[wr_idx] = wr_en; sfl[wr_idx] = wr_flip;
      end
      if (m_commit) begin
         for (int i = 0; i < NF; i++) begin
            ax[i] = sx[i]; ay[i] = sy[i]; aen[i] = sen[i]; afl[i] = sfl[i];
         end
         m_ovl = 0;
         m_cnt = (m_cnt + 1) % 256;
      end else if (nh >= 2) begin
         m_ovl = 1;
      end
      m_commit = fs;
      checks++;
      if (overlap !== m_ovl || frame_cnt !== 8'(m_cnt)) begin
         errors++;
         $display("FAIL status: got ovl %b cnt %0d, want ovl %b cnt %0d", overlap, frame_cnt, m_ovl, m_cnt);
      end
      if (q.size() >= 2) begin
         got = '{pix_valid, pix_color, pix_idx};
         e = q.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL pixel: got v%b c%h i%0d, want v%b c%h i%0d", got.v, got.c, got.i, e.v, e.c, e.i);
         end
      end
      frame_start = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(0, 0, 0, 0);
   endtask

   task automatic do_write(input int idx, input int x, input int y, input bit en, input bit fl);
      wr_idx = 3'(idx); wr_x = 10'(x); wr_y = 10'(y); wr_en = en; wr_flip = fl;
      wr_valid = 1'b1;
      cycle(0, 0, 0, 0);
      wr_valid = 1'b0;
   endtask

   task automatic do_commit();
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", wr_ready); end
      reset = 1'b0;
      model_clear();
      #1;
      checks++;
      if (pix_valid !== 1'b0 || pix_color !== 12'h000 || frame_cnt !== 8'd0 || wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: got v%b c%h cnt %0d rdy %b, want 0 000 0 1", pix_valid, pix_color, frame_cnt, wr_ready);
      end
      cycle(104, 51, 1, 0);
      cycle(500, 300, 1, 0);
      idle(2);
   endtask

   task automatic test_basic();
      do_write(0, 100, 50, 1, 0);
      do_commit();
      cycle(104, 51, 1, 0);
      cycle(0, 0, 0, 0);
      checks++;
      if (pix_valid !== 1'b1 || pix_color !== 12'hFC6 || pix_idx !== 3'd0) begin
         errors++;
         $display("FAIL basic_pixel: got v%b c%h i%0d, want 1 fc6 0", pix_valid, pix_color, pix_idx);
      end
      idle(1);
   endtask

   task automatic test_overlap();
      int c0;
      do_write(0, 200, 60, 1, 0);
      do_write(1, 200, 60, 1, 0);
      do_commit();
      cycle(203, 62, 1, 0);
      cycle(0, 0, 0, 0);
      checks++;
      if (pix_idx !== 3'd0 || overlap !== 1'b1) begin
         errors++;
         $display("FAIL overlap_set: got idx %0d ovl %b, want 0 1", pix_idx, overlap);
      end
      c0 = int'(frame_cnt);
      do_commit();
      checks++;
      if (overlap !== 1'b0 || int'(frame_cnt) !== (c0 + 1) % 256) begin
         errors++;
         $display("FAIL overlap_clear: got ovl %b cnt %0d, want 0 %0d", overlap, frame_cnt, (c0 + 1) % 256);
      end
   endtask

   task automatic test_shadow();
      do_write(2, 300, 100, 1, 0);
      do_write(5, 301, 100, 1, 0);
      cycle(301, 100, 1, 0);
      do_commit();
      cycle(301, 100, 1, 0);
      cycle(300, 100, 1, 0);
      idle(2);
      cycle(0, 0, 0, 1);
      wr_idx = 3'd2; wr_x = 10'd310; wr_y = 10'd100; wr_en = 1'b1; wr_flip = 1'b0;
      wr_valid = 1'b1;
      #1;
      checks++;
      if (wr_ready !== 1'b0) begin errors++; $display("FAIL commit_ready: got %b want 0", wr_ready); end
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      wr_valid = 1'b0;
      do_commit();
      cycle(312, 101, 1, 0);
      idle(2);
   endtask

   task automatic test_edge();
      do_write(3, 1020, 400, 1, 0);
      do_commit();
      cycle(1023, 401, 1, 0);
      cycle(0, 401, 1, 0);
      cycle(1020, 402, 1, 0);
      cycle(1023, 407, 1, 0);
      cycle(1023, 408, 1, 0);
      idle(2);
   endtask

   task automatic test_back_to_back();
      for (int h = 308; h < 327; h++) cycle(h, 101, 1, 0);
      for (int h = 198; h < 216; h++) cycle(h, 61, (h % 5) != 0, 0);
      idle(2);
   endtask

`ifdef FISH_FLIP_EN
   task automatic test_flip();
      do_write(0, 100, 50, 1, 1);
      do_commit();
      cycle(100, 50, 1, 0);
      checks++;
      if (rom_col !== 4'd14) begin errors++; $display("FAIL flip_col: got %0d want 14", rom_col); end
      cycle(110, 51, 1, 0);
      idle(2);
   endtask
`endif

   task automatic test_reset_mid();
      do_write(0, 100, 50, 1, 0);
      do_commit();
      cycle(104, 51, 1, 0);
      cycle(105, 51, 1, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (pix_valid !== 1'b0 || pix_color !== 12'h000) begin
         errors++;
         $display("FAIL reset_mid: got v%b c%h, want 0 000", pix_valid, pix_color);
      end
      reset = 1'b0;
      model_clear();
      cycle(104, 51, 1, 0);
      cycle(203, 62, 1, 0);
      cycle(1023, 401, 1, 0);
      idle(2);
   endtask

   initial begin
      model_clear();
      test_reset();
      test_basic();
      test_overlap();
      test_shadow();
      test_edge();
      test_back_to_back();
`ifdef FISH_FLIP_EN
      test_flip();
`endif
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
